// File: rtl/weight_reg_bank_seq_if.sv
// weight_reg_bank_seq_if: write/burst/read bundle between the neuron controller and the weight bank.
interface weight_reg_bank_seq_if #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_WEIGHTS  = 4
);
    localparam int ADDR_WIDTH = $clog2(NUM_WEIGHTS);
    logic [WEIGHT_WIDTH-1:0]             dataIn;
    logic [ADDR_WIDTH-1:0]               address;
    logic                                write;
    logic                                loadStart;
    logic                                inValid;
    logic                                inReady;
    logic [ADDR_WIDTH-1:0]               rdAddr;
    logic [WEIGHT_WIDTH-1:0]             rdData;
    logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weightsFlat;
    logic                                bankValid;
    logic                                loadDone;
    modport master (
        output dataIn, address, write, loadStart, inValid, rdAddr,
        input  inReady, rdData, weightsFlat, bankValid, loadDone
    );
    modport slave (
        input  dataIn, address, write, loadStart, inValid, rdAddr,
        output inReady, rdData, weightsFlat, bankValid, loadDone
    );
endinterface

// File: rtl/weight_reg_bank_seq.sv
// weight_reg_bank_seq: weight bank with addressed writes, handshaked burst load and registered read.
// Optional WEIGHT_SHADOW_EN stages bursts in a shadow bank committed atomically on the last beat.
module weight_reg_bank_seq #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int NUM_WEIGHTS  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    weight_reg_bank_seq_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(NUM_WEIGHTS);
    typedef enum logic {IDLE, BURST} state_t;
    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] w_q [NUM_WEIGHTS];
    logic [WEIGHT_WIDTH-1:0] w_d [NUM_WEIGHTS];
    logic [WEIGHT_WIDTH-1:0] rd_q, rd_d;
    logic                    bank_valid_q, bank_valid_d;
    logic                    load_done_q, load_done_d;
`ifdef WEIGHT_SHADOW_EN
    logic [WEIGHT_WIDTH-1:0] sh_q [NUM_WEIGHTS];
    logic [WEIGHT_WIDTH-1:0] sh_d [NUM_WEIGHTS];
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        w_d          = w_q;
        bank_valid_d = bank_valid_q;
        load_done_d  = 1'b0;
        rd_d         = '0;
`ifdef WEIGHT_SHADOW_EN
        sh_d         = sh_q;
`endif
        // Decoded compares leave out-of-range addresses with no matching entry.
        for (int i = 0; i < NUM_WEIGHTS; i++)
            if (bus.rdAddr == ADDR_WIDTH'(i)) rd_d = w_q[i];
        if (state_q == IDLE) begin
            if (bus.loadStart) begin
                state_d      = BURST;
                ptr_d        = '0;
                bank_valid_d = 1'b0;
            end else if (bus.write) begin
                for (int i = 0; i < NUM_WEIGHTS; i++)
                    if (bus.address == ADDR_WIDTH'(i)) begin
                        w_d[i] = bus.dataIn;
`ifdef WEIGHT_SHADOW_EN
                        sh_d[i] = bus.dataIn;
`endif
                    end
            end
        end else if (bus.loadStart) begin
            ptr_d = '0;
        end else if (bus.inValid) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
            for (int i = 0; i < NUM_WEIGHTS; i++)
                if (ptr_q == ADDR_WIDTH'(i)) begin
`ifdef WEIGHT_SHADOW_EN
                    sh_d[i] = bus.dataIn;
`else
                    w_d[i] = bus.dataIn;
`endif
                end
            if (ptr_q == ADDR_WIDTH'(NUM_WEIGHTS - 1)) begin
                state_d      = IDLE;
                ptr_d        = '0;
                bank_valid_d = 1'b1;
                load_done_d  = 1'b1;
`ifdef WEIGHT_SHADOW_EN
                w_d          = sh_d;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            w_q          <= '{default: '0};
            rd_q         <= '0;
            bank_valid_q <= 1'b0;
            load_done_q  <= 1'b0;
`ifdef WEIGHT_SHADOW_EN
            sh_q         <= '{default: '0};
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            w_q          <= w_d;
            rd_q         <= rd_d;
            bank_valid_q <= bank_valid_d;
            load_done_q  <= load_done_d;
`ifdef WEIGHT_SHADOW_EN
            sh_q         <= sh_d;
`endif
        end
    end

    assign bus.inReady   = state_q == BURST;
    assign bus.rdData    = rd_q;
    assign bus.bankValid = bank_valid_q;
    assign bus.loadDone  = load_done_q;
    for (genvar g = 0; g < NUM_WEIGHTS; g++) begin : g_flat
        assign bus.weightsFlat[g*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_q[g];
    end
endmodule
